// File: rtl/refclk_pkg.sv
// Shared types, defaults and the loss-lookup helper for the reference-clock selector.
// Feature macro REFCLK_SEL_REVERT_EN (revertive wait-to-restore) is consumed by the other files.
package refclk_pkg;

    typedef enum logic [2:0] {
        ST_DIS  = 3'd0,
        ST_PRI  = 3'd1,
        ST_HOLD = 3'd2,
        ST_SEC  = 3'd3,
        ST_WTR  = 3'd4,
        ST_FAIL = 3'd5
    } refsel_state_e;

    localparam int DEF_N_IN       = 11;
    localparam int DEF_N_OUT      = 10;
    localparam int DEF_HOLDOFF_MS = 2;
    localparam int DEF_WTR_MS     = 300;

    // Loss vectors and indices are padded to these widths before lookup (N_IN <= 64).
    localparam int LOSS_MAX_IN = 64;
    localparam int LOSS_IDX_W  = 6;

    function automatic logic idx_lost(input logic [LOSS_MAX_IN-1:0] loss,
                                      input logic [LOSS_IDX_W-1:0]  idx,
                                      input int                     n_in);
        return (int'(idx) < n_in) ? loss[idx] : 1'b1;
    endfunction

endpackage

// File: rtl/refclk_sel_ch.sv
// One output channel: protection FSM, hold-off / wait-to-restore counters and clock mux.
// REFCLK_SEL_REVERT_EN builds the WTR state and its counter; otherwise the channel is non-revertive.
module refclk_sel_ch
    import refclk_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int SEL_W      = 4,
    parameter int HOLDOFF_MS = DEF_HOLDOFF_MS
`ifdef REFCLK_SEL_REVERT_EN
    ,
    parameter int WTR_MS     = DEF_WTR_MS
`endif
) (
    input  logic             clk_125m,
    input  logic             rst_n,
    input  logic             tick_1ms,
    input  logic [N_IN-1:0]  refck_in,
    input  logic [N_IN-1:0]  clk_loss,
    input  logic             ref_en,
    input  logic             auto_en,
    input  logic             force_sec,
    input  logic [SEL_W-1:0] pri_sel,
    input  logic [SEL_W-1:0] sec_sel,
    output logic             refck_out,
    output logic [SEL_W-1:0] active_sel,
    output logic             on_sec,
    output logic             switch_evt,
    output logic             alarm
);

    localparam int HOLD_CW = (HOLDOFF_MS > 0) ? $clog2(HOLDOFF_MS + 1) : 1;
    localparam logic [HOLD_CW-1:0] HOLD_MAX = HOLD_CW'(HOLDOFF_MS);

    refsel_state_e      state_r, state_s;
    logic [SEL_W-1:0]   active_sel_r, active_sel_s;
    logic               on_sec_r, on_sec_s;
    logic               switch_evt_r, switch_evt_s;
    logic               alarm_r;
    logic               force_sec_r;
    logic [HOLD_CW-1:0] hold_cnt_r, hold_cnt_s, hold_inc_s;
    logic               loss_p_s, loss_s_s, force_fall_s, refck_mux_s;

`ifdef REFCLK_SEL_REVERT_EN
    localparam int WTR_CW = (WTR_MS > 0) ? $clog2(WTR_MS + 1) : 1;
    localparam logic [WTR_CW-1:0] WTR_MAX = WTR_CW'(WTR_MS);
    logic [WTR_CW-1:0] wtr_cnt_r, wtr_cnt_s, wtr_inc_s;
    assign wtr_inc_s = (tick_1ms && (wtr_cnt_r != WTR_MAX)) ? wtr_cnt_r + WTR_CW'(1) : wtr_cnt_r;
`endif

    assign loss_p_s     = idx_lost(LOSS_MAX_IN'(clk_loss), LOSS_IDX_W'(pri_sel), N_IN);
    assign loss_s_s     = idx_lost(LOSS_MAX_IN'(clk_loss), LOSS_IDX_W'(sec_sel), N_IN);
    assign force_fall_s = force_sec_r & ~force_sec;
    assign hold_inc_s   = (tick_1ms && (hold_cnt_r != HOLD_MAX)) ? hold_cnt_r + HOLD_CW'(1) : hold_cnt_r;

    // Next-state, counter and routing decode for the protection FSM.
    always_comb begin
        state_s = state_r;
        if (!ref_en) begin
            state_s = ST_DIS;
        end else begin
            case (state_r)
                ST_DIS: state_s = ST_PRI;
                ST_PRI: begin
                    if (force_sec) begin
                        state_s = ST_SEC;
                    end else if (auto_en && loss_p_s) begin
                        if (HOLDOFF_MS == 0) begin
                            state_s = loss_s_s ? ST_FAIL : ST_SEC;
                        end else begin
                            state_s = ST_HOLD;
                        end
                    end else begin
                        state_s = ST_PRI;
                    end
                end
                ST_HOLD: begin
                    if (!loss_p_s)                    state_s = ST_PRI;
                    else if (force_sec)               state_s = ST_SEC;
                    else if (!auto_en)                state_s = ST_PRI;
                    else if (hold_cnt_r == HOLD_MAX)  state_s = loss_s_s ? ST_FAIL : ST_SEC;
                    else                              state_s = ST_HOLD;
                end
                ST_SEC: begin
                    if (loss_s_s && !loss_p_s)                         state_s = ST_PRI;
                    else if (loss_s_s)                                 state_s = ST_FAIL;
                    else if (force_fall_s || (!auto_en && !force_sec)) state_s = ST_PRI;
`ifdef REFCLK_SEL_REVERT_EN
                    else if (!loss_p_s && !force_sec)                  state_s = ST_WTR;
`endif
                    else                                               state_s = ST_SEC;
                end
`ifdef REFCLK_SEL_REVERT_EN
                ST_WTR: begin
                    if (loss_p_s)                   state_s = ST_SEC;
                    else if (loss_s_s)              state_s = ST_PRI;
                    else if (force_sec)             state_s = ST_SEC;
                    else if (!auto_en)              state_s = ST_PRI;
                    else if (wtr_cnt_r == WTR_MAX)  state_s = ST_PRI;
                    else                            state_s = ST_WTR;
                end
`endif
                ST_FAIL: begin
                    if (!loss_p_s)       state_s = ST_PRI;
                    else if (!loss_s_s)  state_s = ST_SEC;
                    else                 state_s = ST_FAIL;
                end
                default: state_s = ST_DIS;
            endcase
        end

        // Counters only run while staying in their state, so an entry-cycle tick is ignored.
        hold_cnt_s = ((state_r == ST_HOLD) && (state_s == ST_HOLD)) ? hold_inc_s : {HOLD_CW{1'b0}};
`ifdef REFCLK_SEL_REVERT_EN
        wtr_cnt_s  = ((state_r == ST_WTR) && (state_s == ST_WTR)) ? wtr_inc_s : {WTR_CW{1'b0}};
`endif

        case (state_s)
            ST_PRI, ST_HOLD: begin
                active_sel_s = pri_sel;
                on_sec_s     = 1'b0;
            end
            ST_SEC, ST_WTR: begin
                active_sel_s = sec_sel;
                on_sec_s     = 1'b1;
            end
            ST_FAIL: begin
                active_sel_s = active_sel_r;
                on_sec_s     = on_sec_r;
            end
            default: begin
                active_sel_s = {SEL_W{1'b0}};
                on_sec_s     = 1'b0;
            end
        endcase

        switch_evt_s = (state_r != ST_DIS) && (state_s != ST_DIS) && (on_sec_s != on_sec_r);
    end

    // State and all channel outputs register together from the next-state decode.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_DIS;
            active_sel_r <= {SEL_W{1'b0}};
            on_sec_r     <= 1'b0;
            switch_evt_r <= 1'b0;
            alarm_r      <= 1'b0;
            force_sec_r  <= 1'b0;
            hold_cnt_r   <= {HOLD_CW{1'b0}};
`ifdef REFCLK_SEL_REVERT_EN
            wtr_cnt_r    <= {WTR_CW{1'b0}};
`endif
        end else begin
            state_r      <= state_s;
            active_sel_r <= active_sel_s;
            on_sec_r     <= on_sec_s;
            switch_evt_r <= switch_evt_s;
            alarm_r      <= (state_s == ST_FAIL);
            force_sec_r  <= force_sec;
            hold_cnt_r   <= hold_cnt_s;
`ifdef REFCLK_SEL_REVERT_EN
            wtr_cnt_r    <= wtr_cnt_s;
`endif
        end
    end

    // Clock mux; an out-of-range index matches no input and yields 0.
    always_comb begin
        refck_mux_s = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            refck_mux_s = refck_mux_s | (refck_in[k] & (active_sel_r == SEL_W'(k)));
        end
    end

    assign refck_out  = ref_en & refck_mux_s;
    assign active_sel = active_sel_r;
    assign on_sec     = on_sec_r;
    assign switch_evt = switch_evt_r;
    assign alarm      = alarm_r;

endmodule

// File: rtl/refclk_sel_auto.sv
// N_IN-to-N_OUT reference-clock selector with per-output automatic failover.
// Define REFCLK_SEL_REVERT_EN for revertive operation (adds the WTR_MS parameter).
module refclk_sel_auto
    import refclk_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int HOLDOFF_MS = DEF_HOLDOFF_MS,
`ifdef REFCLK_SEL_REVERT_EN
    parameter int WTR_MS     = DEF_WTR_MS,
`endif
    localparam int SEL_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk_125m,
    input  logic                   rst_n,
    input  logic                   tick_1ms,
    input  logic [N_IN-1:0]        refck_in,
    input  logic [N_IN-1:0]        clk_loss,
    input  logic [N_OUT-1:0]       ref_en,
    input  logic [N_OUT-1:0]       auto_en,
    input  logic [N_OUT-1:0]       force_sec,
    input  logic [N_OUT*SEL_W-1:0] pri_sel,
    input  logic [N_OUT*SEL_W-1:0] sec_sel,
    output logic [N_OUT-1:0]       refck_out,
    output logic [N_OUT*SEL_W-1:0] active_sel,
    output logic [N_OUT-1:0]       on_sec,
    output logic [N_OUT-1:0]       switch_evt,
    output logic [N_OUT-1:0]       alarm
);

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        refclk_sel_ch #(
            .N_IN       (N_IN),
            .SEL_W      (SEL_W),
            .HOLDOFF_MS (HOLDOFF_MS)
`ifdef REFCLK_SEL_REVERT_EN
            ,
            .WTR_MS     (WTR_MS)
`endif
        ) u_ch (
            .clk_125m   (clk_125m),
            .rst_n      (rst_n),
            .tick_1ms   (tick_1ms),
            .refck_in   (refck_in),
            .clk_loss   (clk_loss),
            .ref_en     (ref_en[i]),
            .auto_en    (auto_en[i]),
            .force_sec  (force_sec[i]),
            .pri_sel    (pri_sel[i*SEL_W +: SEL_W]),
            .sec_sel    (sec_sel[i*SEL_W +: SEL_W]),
            .refck_out  (refck_out[i]),
            .active_sel (active_sel[i*SEL_W +: SEL_W]),
            .on_sec     (on_sec[i]),
            .switch_evt (switch_evt[i]),
            .alarm      (alarm[i])
        );
    end

endmodule

// File: tb/tb_refclk_sel_auto.sv
// Directed bench for refclk_sel_auto: vector table on output 0 plus multi-cycle sequences.
// Builds with or without REFCLK_SEL_REVERT_EN.
module tb_refclk_sel_auto;

    localparam int N_IN  = 11;
    localparam int N_OUT = 2;
    localparam int SW    = 4;

    logic              clk_125m;
    logic              rst_n;
    logic              tick_1ms;
    logic [N_IN-1:0]   refck_in;
    logic [N_IN-1:0]   clk_loss;
    logic [N_OUT-1:0]  ref_en, auto_en, force_sec;
    logic [N_OUT*SW-1:0] pri_sel, sec_sel, active_sel;
    logic [N_OUT-1:0]  refck_out, on_sec, switch_evt, alarm;

    int n_checks = 0;
    int n_errors = 0;

    refclk_sel_auto #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .HOLDOFF_MS (2)
`ifdef REFCLK_SEL_REVERT_EN
        ,
        .WTR_MS     (4)
`endif
    ) dut (
        .clk_125m   (clk_125m),
        .rst_n      (rst_n),
        .tick_1ms   (tick_1ms),
        .refck_in   (refck_in),
        .clk_loss   (clk_loss),
        .ref_en     (ref_en),
        .auto_en    (auto_en),
        .force_sec  (force_sec),
        .pri_sel    (pri_sel),
        .sec_sel    (sec_sel),
        .refck_out  (refck_out),
        .active_sel (active_sel),
        .on_sec     (on_sec),
        .switch_evt (switch_evt),
        .alarm      (alarm)
    );

    initial clk_125m = 1'b0;
    always #5 clk_125m = ~clk_125m;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1);
    end

    typedef struct {
        logic en, au, fr, l3, l5, tk;
        logic [3:0] sel;
        logic on, ev, al, ck;
    } vec_t;

    vec_t tv [26];

    function automatic vec_t mk(input logic en, au, fr, l3, l5, tk,
                                input logic [3:0] sel, input logic on, ev, al, ck);
        vec_t v;
        v.en = en; v.au = au; v.fr = fr; v.l3 = l3; v.l5 = l5; v.tk = tk;
        v.sel = sel; v.on = on; v.ev = ev; v.al = al; v.ck = ck;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic tk);
        tick_1ms = tk;
        @(posedge clk_125m);
        #1;
        tick_1ms = 1'b0;
    endtask

    initial begin
        // en au fr l3 l5 tk | sel on ev al ck   (output 0: pri=3, sec=5; refck_in has bits 3 and 4 set)
        tv[0]  = mk(1,1,0,0,0,0, 4'd3,0,0,0,1);
        tv[1]  = mk(1,1,0,0,0,1, 4'd3,0,0,0,1);
        tv[2]  = mk(1,1,0,1,0,0, 4'd3,0,0,0,1);
        tv[3]  = mk(1,1,0,1,0,1, 4'd3,0,0,0,1);
        tv[4]  = mk(1,1,0,0,0,0, 4'd3,0,0,0,1);
        tv[5]  = mk(1,1,0,1,0,0, 4'd3,0,0,0,1);
        tv[6]  = mk(1,1,0,1,0,1, 4'd3,0,0,0,1);
        tv[7]  = mk(1,1,0,1,0,0, 4'd3,0,0,0,1);
        tv[8]  = mk(1,1,0,1,0,1, 4'd3,0,0,0,1);
        tv[9]  = mk(1,1,0,1,0,0, 4'd5,1,1,0,0);
        tv[10] = mk(1,1,0,1,0,0, 4'd5,1,0,0,0);
        tv[11] = mk(1,1,0,1,1,0, 4'd5,1,0,1,0);
        tv[12] = mk(1,1,0,1,1,0, 4'd5,1,0,1,0);
        tv[13] = mk(1,1,0,0,1,0, 4'd3,0,1,0,1);
        tv[14] = mk(1,1,1,0,0,0, 4'd5,1,1,0,0);
        tv[15] = mk(1,1,1,0,0,0, 4'd5,1,0,0,0);
        tv[16] = mk(1,1,0,0,0,0, 4'd3,0,1,0,1);
        tv[17] = mk(1,1,1,1,0,0, 4'd5,1,1,0,0);
        tv[18] = mk(1,1,1,1,1,0, 4'd5,1,0,1,0);
        tv[19] = mk(1,1,0,1,0,0, 4'd5,1,0,0,0);
        tv[20] = mk(1,1,0,0,1,0, 4'd3,0,1,0,1);
        tv[21] = mk(1,0,0,1,0,0, 4'd3,0,0,0,1);
        tv[22] = mk(1,1,0,1,0,0, 4'd3,0,0,0,1);
        tv[23] = mk(1,0,0,1,0,0, 4'd3,0,0,0,1);
        tv[24] = mk(0,1,0,0,0,0, 4'd0,0,0,0,0);
        tv[25] = mk(1,1,0,0,0,0, 4'd3,0,0,0,1);

        rst_n     = 1'b0;
        tick_1ms  = 1'b0;
        refck_in  = 11'b000_0001_1000;
        clk_loss  = 11'd0;
        ref_en    = 2'b01;
        auto_en   = 2'b11;
        force_sec = 2'b00;
        pri_sel   = {4'd12, 4'd3};
        sec_sel   = {4'd4, 4'd5};
        #22;
        rst_n = 1'b1;
        #1;
        chk("reset_active_sel", 32'(active_sel), 32'd0);
        chk("reset_on_sec",     32'(on_sec),     32'd0);
        chk("reset_switch_evt", 32'(switch_evt), 32'd0);
        chk("reset_alarm",      32'(alarm),      32'd0);
        chk("reset_refck_out1", 32'(refck_out[1]), 32'd0);

        for (int i = 0; i < 26; i++) begin
            ref_en[0]    = tv[i].en;
            auto_en[0]   = tv[i].au;
            force_sec[0] = tv[i].fr;
            clk_loss[3]  = tv[i].l3;
            clk_loss[5]  = tv[i].l5;
            step(tv[i].tk);
            chk($sformatf("v%0d_active_sel", i), 32'(active_sel[3:0]), 32'(tv[i].sel));
            chk($sformatf("v%0d_on_sec", i),     32'(on_sec[0]),       32'(tv[i].on));
            chk($sformatf("v%0d_switch_evt", i), 32'(switch_evt[0]),   32'(tv[i].ev));
            chk($sformatf("v%0d_alarm", i),      32'(alarm[0]),        32'(tv[i].al));
            chk($sformatf("v%0d_refck_out", i),  32'(refck_out[0]),    32'(tv[i].ck));
        end

        // Output 1: primary index 12 is out of range, so it is lost and routes nothing.
        ref_en[1] = 1'b1;
        step(1'b0);
        chk("oor_pri_refck_out", 32'(refck_out[1]), 32'd0);
        chk("oor_pri_on_sec",    32'(on_sec[1]),    32'd0);
        step(1'b0);
        chk("oor_hold_refck_out", 32'(refck_out[1]), 32'd0);
        step(1'b1);
        step(1'b1);
        chk("oor_hold_on_sec", 32'(on_sec[1]), 32'd0);
        step(1'b0);
        chk("oor_sec_on_sec",     32'(on_sec[1]),       32'd1);
        chk("oor_sec_active_sel", 32'(active_sel[7:4]), 32'd4);
        chk("oor_sec_switch_evt", 32'(switch_evt[1]),   32'd1);
        chk("oor_sec_refck_out",  32'(refck_out[1]),    32'd1);
        chk("oor_out0_undisturbed", 32'(on_sec[0]),     32'd0);

        // Reset in the middle of a hold-off on output 0.
        clk_loss[3] = 1'b1;
        step(1'b0);
        step(1'b1);
        chk("hold_before_rst_on_sec", 32'(on_sec[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_active_sel", 32'(active_sel), 32'd0);
        chk("rst_mid_on_sec",     32'(on_sec),     32'd0);
        chk("rst_mid_alarm",      32'(alarm),      32'd0);
        clk_loss[3] = 1'b0;
        ref_en[1]   = 1'b0;
        @(negedge clk_125m);
        rst_n = 1'b1;
        step(1'b0);
        chk("rst_rel_switch_evt", 32'(switch_evt), 32'd0);
        chk("rst_rel_active_sel", 32'(active_sel[3:0]), 32'd3);
        step(1'b0);
        chk("rst_rel_switch_evt2", 32'(switch_evt), 32'd0);

        // Auto switch output 0 to secondary, then restore the primary.
        clk_loss[3] = 1'b1;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("rev_to_sec_on_sec", 32'(on_sec[0]), 32'd1);
        clk_loss[3] = 1'b0;
        step(1'b0);
        chk("rev_restored_on_sec", 32'(on_sec[0]), 32'd1);
        chk("rev_restored_evt",    32'(switch_evt[0]), 32'd0);
`ifdef REFCLK_SEL_REVERT_EN
        for (int t = 0; t < 3; t++) begin
            step(1'b1);
            chk($sformatf("wtr_a_tick%0d_on_sec", t), 32'(on_sec[0]), 32'd1);
        end
        clk_loss[3] = 1'b1;
        step(1'b0);
        chk("wtr_glitch_on_sec", 32'(on_sec[0]), 32'd1);
        clk_loss[3] = 1'b0;
        step(1'b0);
        for (int t = 0; t < 4; t++) begin
            step(1'b1);
            chk($sformatf("wtr_b_tick%0d_on_sec", t), 32'(on_sec[0]), 32'd1);
        end
        step(1'b0);
        chk("wtr_done_on_sec",     32'(on_sec[0]),       32'd0);
        chk("wtr_done_switch_evt", 32'(switch_evt[0]),   32'd1);
        chk("wtr_done_active_sel", 32'(active_sel[3:0]), 32'd3);
`else
        for (int t = 0; t < 6; t++) begin
            step(1'b1);
            chk($sformatf("nonrev_tick%0d_on_sec", t), 32'(on_sec[0]), 32'd1);
        end
        chk("nonrev_active_sel", 32'(active_sel[3:0]), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
